// File: rtl/reg_select_sequencer.sv
// Execute-phase control-step sequencer that drives the register select/encode strobes.
// Define SEQ_ILLEGAL_TRAP_EN to flag unknown opcodes on `illegal` instead of treating them as NOP.
//
// state  | meaning
// S_IDLE | waiting for start (step 0)
// S1..S4 | execute control steps of the latched opcode class
// S5, S6 | reserved encodings, recover to S_IDLE
module reg_select_sequencer #(
    parameter int OPW   = 5,
    parameter int STEPW = 3
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [OPW-1:0]   opcode,
    input  logic             stall,
    output logic             Gra,
    output logic             Grb,
    output logic             Grc,
    output logic             Rin,
    output logic             Rout,
    output logic             BAout,
    output logic             busy,
    output logic             done,
    output logic [STEPW-1:0] step,
    output logic             illegal
);

`ifdef SEQ_ILLEGAL_TRAP_EN
    localparam bit TRAP_EN = 1'b1;
`else
    localparam bit TRAP_EN = 1'b0;
`endif

    typedef enum logic [STEPW-1:0] {
        S_IDLE = 0, S1 = 1, S2 = 2, S3 = 3, S4 = 4, S5 = 5, S6 = 6
    } state_t;

    typedef enum logic [2:0] {
        C_R, C_I, C_U, C_LDI, C_LD, C_ST, C_NOP
    } class_t;

    function automatic class_t decode_class(input logic [OPW-1:0] op);
        case (op)
            OPW'(3), OPW'(4), OPW'(5), OPW'(6),
            OPW'(7), OPW'(8), OPW'(9), OPW'(10): decode_class = C_R;
            OPW'(11), OPW'(12), OPW'(13):        decode_class = C_I;
            OPW'(16), OPW'(17):                  decode_class = C_U;
            OPW'(1):                             decode_class = C_LDI;
            OPW'(0):                             decode_class = C_LD;
            OPW'(2):                             decode_class = C_ST;
            default:                             decode_class = C_NOP;
        endcase
    endfunction

    state_t         state_q, state_d;
    logic [OPW-1:0] op_q, op_d;
    logic           illegal_q, illegal_d;

    class_t cls;
    logic   last;
    logic   ga, gb, gc, ri, ro, ba;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= S_IDLE;
            op_q      <= '0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            illegal_q <= illegal_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        illegal_d = illegal_q;
        cls       = decode_class(op_q);
        last      = 1'b0;
        {ga, gb, gc, ri, ro, ba} = 6'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d   = S1;
                    op_d      = opcode;
                    illegal_d = TRAP_EN && (decode_class(opcode) == C_NOP);
                end
            end
            S1: begin
                case (cls)
                    C_R, C_I, C_U:      {gb, ro} = 2'b11;
                    C_LDI, C_LD, C_ST:  {gb, ba} = 2'b11;
                    default:            last = 1'b1;
                endcase
            end
            S2: begin
                case (cls)
                    C_R:     {gc, ro} = 2'b11;
                    C_U: begin
                        {ga, ri} = 2'b11;
                        last     = 1'b1;
                    end
                    default: ;
                endcase
            end
            S3: begin
                case (cls)
                    C_R, C_I, C_LDI: begin
                        {ga, ri} = 2'b11;
                        last     = 1'b1;
                    end
                    C_ST:    {ga, ro} = 2'b11;
                    default: ;
                endcase
            end
            S4:      last = 1'b1;
            default: last = 1'b1;
        endcase

        // LD writes back in S4; ST's S4 is the memory write cycle with no strobes.
        if (state_q == S4 && cls == C_LD) begin
            {ga, ri} = 2'b11;
        end

        if (state_q != S_IDLE && !stall) begin
            state_d = last ? S_IDLE : state_t'(state_q + STEPW'(1));
        end

        // Strobes drop while stalled so a held write step cannot fire twice.
        Gra   = ga & ~stall;
        Grb   = gb & ~stall;
        Grc   = gc & ~stall;
        Rin   = ri & ~stall;
        Rout  = ro & ~stall;
        BAout = ba & ~stall;
        done  = last & ~illegal_q;
    end

    assign step    = state_q;
    assign busy    = (state_q != S_IDLE);
    assign illegal = illegal_q;

endmodule

// File: tb/tb_reg_select_sequencer.sv
// Directed self-checking bench for reg_select_sequencer (default build, trap feature off).
module tb_reg_select_sequencer;

    logic       clock;
    logic       reset;
    logic       start;
    logic [4:0] opcode;
    logic       stall;
    logic       Gra, Grb, Grc, Rin, Rout, BAout;
    logic       busy, done, illegal;
    logic [2:0] step;

    int total  = 0;
    int passed = 0;

    reg_select_sequencer #(.OPW(5), .STEPW(3)) dut (
        .clock   (clock),
        .reset   (reset),
        .start   (start),
        .opcode  (opcode),
        .stall   (stall),
        .Gra     (Gra),
        .Grb     (Grb),
        .Grc     (Grc),
        .Rin     (Rin),
        .Rout    (Rout),
        .BAout   (BAout),
        .busy    (busy),
        .done    (done),
        .step    (step),
        .illegal (illegal)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Strobe vector order: {Gra, Grb, Grc, Rin, Rout, BAout}
    localparam logic [5:0] SB_NONE   = 6'b000000;
    localparam logic [5:0] SB_GRB_RO = 6'b010010;
    localparam logic [5:0] SB_GRC_RO = 6'b001010;
    localparam logic [5:0] SB_GRA_RI = 6'b100100;
    localparam logic [5:0] SB_GRB_BA = 6'b010001;
    localparam logic [5:0] SB_GRA_RO = 6'b100010;

    logic [11:0] got_vec;
    assign got_vec = {step, busy, done, illegal, Gra, Grb, Grc, Rin, Rout, BAout};

    task automatic check(input string tag, input logic [11:0] got, input logic [11:0] exp);
        total++;
        if (got !== exp)
            $display("FAIL %s got=%b exp=%b (step,busy,done,illegal,Gra,Grb,Grc,Rin,Rout,BAout)",
                     tag, got, exp);
        else
            passed++;
    endtask

    function automatic logic [11:0] ev(input int st, input bit dn, input logic [5:0] sb);
        logic [2:0] s;
        s  = st[2:0];
        ev = {s, (st != 0), dn, 1'b0, sb};
    endfunction

    // Sample outputs mid-cycle, then advance to just after the next rising edge.
    task automatic cyc(input string tag, input int st, input bit dn, input logic [5:0] sb);
        @(negedge clock);
        check(tag, got_vec, ev(st, dn, sb));
        @(posedge clock);
        #1;
    endtask

    task automatic launch(input logic [4:0] op);
        opcode = op;
        start  = 1'b1;
        cyc("idle_start", 0, 0, SB_NONE);
        start  = 1'b0;
        opcode = 5'b10101;
    endtask

    always @(negedge clock) begin
        if (!reset) begin
            check("inv_onehot",
                  {11'b0, ($countones({Gra, Grb, Grc}) <= 1) &&
                          ($countones({Rin, Rout, BAout}) <= 1)},
                  12'd1);
        end
    end

    initial begin
        reset  = 1'b1;
        start  = 1'b0;
        stall  = 1'b0;
        opcode = 5'd0;
        @(posedge clock);
        @(posedge clock);
        #1;
        cyc("reset_state", 0, 0, SB_NONE);
        reset = 1'b0;
        cyc("idle_quiet", 0, 0, SB_NONE);

        // add: three steps
        launch(5'b00011);
        cyc("add_s1", 1, 0, SB_GRB_RO);
        cyc("add_s2", 2, 0, SB_GRC_RO);
        cyc("add_s3", 3, 1, SB_GRA_RI);
        cyc("add_idle", 0, 0, SB_NONE);

        // ld with two stall cycles in S3
        launch(5'b00000);
        cyc("ld_s1", 1, 0, SB_GRB_BA);
        cyc("ld_s2", 2, 0, SB_NONE);
        stall = 1'b1;
        cyc("ld_s3_stall_a", 3, 0, SB_NONE);
        cyc("ld_s3_stall_b", 3, 0, SB_NONE);
        stall = 1'b0;
        cyc("ld_s3", 3, 0, SB_NONE);
        cyc("ld_s4", 4, 1, SB_GRA_RI);
        cyc("ld_idle", 0, 0, SB_NONE);

        // sub with stall in S2: strobes forced low, then resume on the held step
        launch(5'b00100);
        cyc("sub_s1", 1, 0, SB_GRB_RO);
        stall = 1'b1;
        cyc("sub_s2_stall", 2, 0, SB_NONE);
        stall = 1'b0;
        cyc("sub_s2", 2, 0, SB_GRC_RO);
        cyc("sub_s3", 3, 1, SB_GRA_RI);
        cyc("sub_idle", 0, 0, SB_NONE);

        // st
        launch(5'b00010);
        cyc("st_s1", 1, 0, SB_GRB_BA);
        cyc("st_s2", 2, 0, SB_NONE);
        cyc("st_s3", 3, 0, SB_GRA_RO);
        cyc("st_s4", 4, 1, SB_NONE);
        cyc("st_idle", 0, 0, SB_NONE);

        // neg with start re-pulsed in its done step
        launch(5'b10000);
        cyc("neg_s1", 1, 0, SB_GRB_RO);
        start  = 1'b1;
        opcode = 5'b00011;
        cyc("neg_s2", 2, 1, SB_GRA_RI);
        start  = 1'b0;
        cyc("neg_idle_a", 0, 0, SB_NONE);
        cyc("neg_idle_b", 0, 0, SB_NONE);

        // unknown opcode behaves as NOP
        launch(5'b11111);
        cyc("nop_s1", 1, 1, SB_NONE);
        cyc("nop_idle", 0, 0, SB_NONE);

        // addi, ldi, not
        launch(5'b01011);
        cyc("addi_s1", 1, 0, SB_GRB_RO);
        cyc("addi_s2", 2, 0, SB_NONE);
        cyc("addi_s3", 3, 1, SB_GRA_RI);
        launch(5'b00001);
        cyc("ldi_s1", 1, 0, SB_GRB_BA);
        cyc("ldi_s2", 2, 0, SB_NONE);
        cyc("ldi_s3", 3, 1, SB_GRA_RI);
        launch(5'b10001);
        cyc("not_s1", 1, 0, SB_GRB_RO);
        cyc("not_s2", 2, 1, SB_GRA_RI);

        // stall in IDLE does not block start (andi)
        stall  = 1'b1;
        opcode = 5'b01100;
        start  = 1'b1;
        cyc("andi_idle_stall", 0, 0, SB_NONE);
        start  = 1'b0;
        stall  = 1'b0;
        cyc("andi_s1", 1, 0, SB_GRB_RO);
        cyc("andi_s2", 2, 0, SB_NONE);
        cyc("andi_s3", 3, 1, SB_GRA_RI);

        // reset mid-ld at step 2 aborts without done
        launch(5'b00000);
        cyc("ldr_s1", 1, 0, SB_GRB_BA);
        reset = 1'b1;
        cyc("ldr_s2", 2, 0, SB_NONE);
        reset = 1'b0;
        cyc("ldr_abort", 0, 0, SB_NONE);
        cyc("ldr_idle", 0, 0, SB_NONE);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
